// File: rtl/bsg_mcl_rx_arbiter_if.sv
// Bundle between the manycore link endpoint (master) and the host receive arbiter (slave):
// two packet streams in, one serialized word stream out, plus drain pulses and credit readback.
interface bsg_mcl_rx_arbiter_if #(
    parameter int fifo_width_p = 128,
    parameter int data_width_p = 32,
    parameter int rcv_els_p    = 64
);
    localparam int vac_width_lp = $clog2(rcv_els_p + 1);

    logic                    rsp_v;
    logic [fifo_width_p-1:0] rsp_data;
    logic                    rsp_ready;
    logic                    req_v;
    logic [fifo_width_p-1:0] req_data;
    logic                    req_ready;
    logic                    word_v;
    logic [data_width_p-1:0] word_data;
    logic                    word_src;
    logic                    word_last;
    logic                    word_yumi;
    logic                    rsp_drain;
    logic                    req_drain;
    logic [vac_width_lp-1:0] rsp_vacancy;
    logic [vac_width_lp-1:0] req_vacancy;
    logic                    credit_err;

    modport master (
        output rsp_v, rsp_data, req_v, req_data, word_yumi, rsp_drain, req_drain,
        input  rsp_ready, req_ready, word_v, word_data, word_src, word_last,
               rsp_vacancy, req_vacancy, credit_err
    );

    modport slave (
        input  rsp_v, rsp_data, req_v, req_data, word_yumi, rsp_drain, req_drain,
        output rsp_ready, req_ready, word_v, word_data, word_src, word_last,
               rsp_vacancy, req_vacancy, credit_err
    );
endinterface

// File: rtl/bsg_mcl_rx_arbiter.sv
// Round-robin, credit-gated arbiter that serializes 128-bit response/request packets
// onto the single 32-bit host receive port, least-significant word first.
module bsg_mcl_rx_arbiter #(
    parameter int fifo_width_p = 128,
    parameter int data_width_p = 32,
    parameter int rcv_els_p    = 64
) (
    input logic                 clk_i,
    input logic                 reset_i,
    bsg_mcl_rx_arbiter_if.slave bus
);
    localparam int els_lp        = fifo_width_p / data_width_p;
    localparam int vac_width_lp  = $clog2(rcv_els_p + 1);
    localparam int beat_width_lp = (els_lp > 1) ? $clog2(els_lp) : 1;
    localparam logic [vac_width_lp-1:0]  vac_max_lp   = vac_width_lp'(rcv_els_p);
    localparam logic [beat_width_lp-1:0] beat_last_lp = beat_width_lp'(els_lp - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

    state_e                    state_r, state_n;
    logic [fifo_width_p-1:0]   shift_r;
    logic [beat_width_lp-1:0]  beat_r;
    logic                      src_r;
    logic                      rr_last_r;
    logic [vac_width_lp-1:0]   rsp_vac_r, req_vac_r;
    logic                      credit_err_r;
    logic                      rsp_elig, req_elig, grant_req;
    logic                      accept_rsp, accept_req, yumi_ok;

    function automatic logic [vac_width_lp-1:0] credit_next(
        input logic [vac_width_lp-1:0] vac, input logic take, input logic drain);
        logic [vac_width_lp-1:0] res;
        res = vac;
        if (take && !drain && vac != '0)
            res = vac - vac_width_lp'(1);
        else if (drain && !take && vac != vac_max_lp)
            res = vac + vac_width_lp'(1);
        return res;
    endfunction

    // A drain that finds the buffer already fully vacant is a host bookkeeping error.
    function automatic logic credit_overflow(
        input logic [vac_width_lp-1:0] vac, input logic take, input logic drain);
        return drain && !take && (vac == vac_max_lp);
    endfunction

    assign rsp_elig   = bus.rsp_v && (rsp_vac_r != '0);
    assign req_elig   = bus.req_v && (req_vac_r != '0);
    // rr_last_r=1 means the request stream went last, so responses win a tie.
    assign grant_req  = req_elig && (!rsp_elig || !rr_last_r);
    assign accept_req = (state_r == IDLE) && grant_req;
    assign accept_rsp = (state_r == IDLE) && rsp_elig && !grant_req;
    assign yumi_ok    = (state_r == SEND) && bus.word_yumi;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= IDLE;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: if (accept_rsp || accept_req) state_n = SEND;
            SEND: if (yumi_ok && beat_r == beat_last_lp) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.rsp_ready = accept_rsp;
        bus.req_ready = accept_req;
        bus.word_v    = (state_r == SEND);
        bus.word_last = (state_r == SEND) && (beat_r == beat_last_lp);
        bus.word_src  = (state_r == SEND) && src_r;
        bus.word_data = (state_r == SEND) ? shift_r[data_width_p-1:0] : '0;
    end

    assign bus.rsp_vacancy = rsp_vac_r;
    assign bus.req_vacancy = req_vac_r;
    assign bus.credit_err  = credit_err_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            beat_r       <= '0;
            src_r        <= 1'b0;
            rr_last_r    <= 1'b1;
            rsp_vac_r    <= vac_max_lp;
            req_vac_r    <= vac_max_lp;
            credit_err_r <= 1'b0;
        end else begin
            if (accept_rsp || accept_req) begin
                beat_r    <= '0;
                src_r     <= accept_req;
                rr_last_r <= accept_req;
            end else if (yumi_ok) begin
                beat_r <= beat_r + beat_width_lp'(1);
            end
            rsp_vac_r <= credit_next(rsp_vac_r, accept_rsp, bus.rsp_drain);
            req_vac_r <= credit_next(req_vac_r, accept_req, bus.req_drain);
            if (credit_overflow(rsp_vac_r, accept_rsp, bus.rsp_drain) ||
                credit_overflow(req_vac_r, accept_req, bus.req_drain))
                credit_err_r <= 1'b1;
        end
    end

    // Packet payload carries no reset; it is only observed while in SEND.
    always_ff @(posedge clk_i) begin
        if (accept_rsp)      shift_r <= bus.rsp_data;
        else if (accept_req) shift_r <= bus.req_data;
        else if (yumi_ok)    shift_r <= shift_r >> data_width_p;
    end
endmodule

// File: tb/tb_bsg_mcl_rx_arbiter.sv
// Bench for bsg_mcl_rx_arbiter: directed scenarios plus a randomized run, all checked
// against a packet-level model (word queue, integer credits, round-robin pointer).
module tb_bsg_mcl_rx_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bsg_mcl_rx_arbiter_if bus ();

    bsg_mcl_rx_arbiter dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: words still owed for the current packet, credits, tie-break pointer.
    logic [31:0] m_words[$];
    bit          m_src;
    int          m_vac[2];
    bit          m_rr_last;
    bit          m_err;

    function automatic void model_reset();
        m_words.delete();
        m_src     = 1'b0;
        m_vac[0]  = 64;
        m_vac[1]  = 64;
        m_rr_last = 1'b1;
        m_err     = 1'b0;
    endfunction

    function automatic int m_grant();
        bit e0, e1;
        e0 = bus.rsp_v && (m_vac[0] > 0);
        e1 = bus.req_v && (m_vac[1] > 0);
        if (m_words.size() != 0) return -1;
        if (e0 && e1) return m_rr_last ? 0 : 1;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    function automatic bit m_busy();
        return m_words.size() != 0;
    endfunction

    function automatic void model_update();
        int g;
        logic [127:0] d;
        bit drain, take;
        if (reset) begin
            model_reset();
            return;
        end
        g = m_grant();
        if (m_busy()) begin
            if (bus.word_yumi) void'(m_words.pop_front());
        end else if (g >= 0) begin
            d = (g == 1) ? bus.req_data : bus.rsp_data;
            for (int i = 0; i < 4; i++) m_words.push_back(d[32*i +: 32]);
            m_src     = (g == 1);
            m_rr_last = (g == 1);
        end
        for (int s = 0; s < 2; s++) begin
            drain = (s == 1) ? bus.req_drain : bus.rsp_drain;
            take  = (g == s);
            if (drain && !take && m_vac[s] == 64) m_err = 1'b1;
            else m_vac[s] = m_vac[s] + (drain ? 1 : 0) - (take ? 1 : 0);
        end
    endfunction

    task automatic drive_idle();
        bus.rsp_v     = 1'b0;
        bus.rsp_data  = '0;
        bus.req_v     = 1'b0;
        bus.req_data  = '0;
        bus.word_yumi = 1'b0;
        bus.rsp_drain = 1'b0;
        bus.req_drain = 1'b0;
    endtask

    task automatic tick();
        if (bus.word_yumi && !bus.word_v) begin
            errors++;
            $display("FAIL yumi_protocol: word_yumi=1 while word_v=%0b, required word_v=1", bus.word_v);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.word_v, bus.word_last, bus.word_src, bus.word_data} !== 35'h0) begin
            errors++;
            $display("FAIL reset_word: v/last/src/data=%b/%b/%b/%h required 0/0/0/0",
                     bus.word_v, bus.word_last, bus.word_src, bus.word_data);
        end
        checks++;
        if ({bus.rsp_ready, bus.req_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b required 00", {bus.rsp_ready, bus.req_ready});
        end
        checks++;
        if (bus.rsp_vacancy !== 7'd64 || bus.req_vacancy !== 7'd64 || bus.credit_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_credit: rsp_vac=%0d req_vac=%0d err=%b required 64 64 0",
                     bus.rsp_vacancy, bus.req_vacancy, bus.credit_err);
        end
    endtask

    task automatic test_single_rsp();
        logic [31:0] exp_w;
        bus.rsp_v    = 1'b1;
        bus.rsp_data = 128'h00004444_00003333_00002222_00001111;
        #1;
        checks++;
        if ({bus.rsp_ready, bus.req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready: got %b required 10", {bus.rsp_ready, bus.req_ready});
        end
        tick();
        bus.rsp_v     = 1'b0;
        bus.word_yumi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_w = 32'h1111 * (i + 1);
            #1;
            checks++;
            if ({bus.word_v, bus.word_data, bus.word_src, bus.word_last} !== {1'b1, exp_w, 1'b0, (i == 3)}) begin
                errors++;
                $display("FAIL single_word%0d: v=%b data=%h src=%b last=%b required 1 %h 0 %b",
                         i, bus.word_v, bus.word_data, bus.word_src, bus.word_last, exp_w, (i == 3));
            end
            tick();
        end
        bus.word_yumi = 1'b0;
        #1;
        checks++;
        if (bus.word_v !== 1'b0 || bus.rsp_vacancy !== 7'd63) begin
            errors++;
            $display("FAIL single_end: v=%b rsp_vac=%0d required 0 63", bus.word_v, bus.rsp_vacancy);
        end
    endtask

    task automatic test_alternate();
        bit exp_rsp, exp_req, exp_v;
        pulse_reset();
        bus.rsp_v = 1'b1;
        bus.req_v = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.word_yumi = m_busy();
            exp_rsp = (c % 5 == 0) && ((c / 5) % 2 == 0);
            exp_req = (c % 5 == 0) && ((c / 5) % 2 == 1);
            exp_v   = (c % 5 != 0);
            #1;
            checks++;
            if ({bus.rsp_ready, bus.req_ready, bus.word_v} !== {exp_rsp, exp_req, exp_v}) begin
                errors++;
                $display("FAIL alt_grant c=%0d: rsp_rdy/req_rdy/v=%b required %b", c,
                         {bus.rsp_ready, bus.req_ready, bus.word_v}, {exp_rsp, exp_req, exp_v});
            end
            if (exp_v) begin
                checks++;
                if (bus.word_src !== 1'((c / 5) % 2) || bus.word_data !== m_words[0]) begin
                    errors++;
                    $display("FAIL alt_word c=%0d: src=%b data=%h required %b %h", c,
                             bus.word_src, bus.word_data, 1'((c / 5) % 2), m_words[0]);
                end
            end
            tick();
        end
        drive_idle();
        #1;
        checks++;
        if (bus.rsp_vacancy !== 7'd62 || bus.req_vacancy !== 7'd62) begin
            errors++;
            $display("FAIL alt_credit: rsp_vac=%0d req_vac=%0d required 62 62",
                     bus.rsp_vacancy, bus.req_vacancy);
        end
    endtask

    task automatic test_credit_exhaust();
        int accepted = 0;
        int late = 0;
        pulse_reset();
        bus.req_v = 1'b1;
        for (int c = 0; c < 65 * 5 + 10; c++) begin
            bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.word_yumi = m_busy();
            #1;
            if (bus.req_ready) accepted++;
            tick();
        end
        checks++;
        if (accepted != 64 || bus.req_vacancy !== 7'd0) begin
            errors++;
            $display("FAIL exhaust_count: accepted=%0d req_vac=%0d required 64 0", accepted, bus.req_vacancy);
        end
        bus.word_yumi = 1'b0;
        bus.req_drain = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_masked: req_ready=%b required 0", bus.req_ready);
        end
        tick();
        bus.req_drain = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.word_yumi = m_busy();
            #1;
            if (bus.req_ready) late++;
            tick();
        end
        checks++;
        if (late != 1) begin
            errors++;
            $display("FAIL exhaust_refill: accepted after drain=%0d required 1", late);
        end
        drive_idle();
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        pulse_reset();
        d = {$urandom, $urandom, $urandom, $urandom};
        bus.rsp_v    = 1'b1;
        bus.rsp_data = d;
        tick();
        bus.rsp_v = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < ((b == 1) ? 4 : 1); k++) begin
                bus.word_yumi = (b != 1) || (k == 3);
                #1;
                checks++;
                if ({bus.word_v, bus.word_data, bus.word_last} !== {1'b1, d[32*b +: 32], (b == 3)}) begin
                    errors++;
                    $display("FAIL bp_beat%0d_%0d: v=%b data=%h last=%b required 1 %h %b", b, k,
                             bus.word_v, bus.word_data, bus.word_last, d[32*b +: 32], (b == 3));
                end
                tick();
            end
        end
        bus.word_yumi = 1'b0;
        #1;
        checks++;
        if (bus.word_v !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: word_v=%b required 0", bus.word_v);
        end
    endtask

    task automatic test_same_cycle();
        bit found = 1'b0;
        pulse_reset();
        bus.rsp_v = 1'b1;
        for (int c = 0; c < 54 * 5 + 20; c++) begin
            bus.rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.word_yumi = m_busy();
            #1;
            if (!bus.word_v && bus.rsp_vacancy == 7'd10) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL same_reach10: rsp_vac=%0d required 10 within bound", bus.rsp_vacancy);
        end
        bus.rsp_drain = 1'b1;
        #1;
        checks++;
        if (bus.rsp_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_ready: rsp_ready=%b required 1", bus.rsp_ready);
        end
        tick();
        bus.rsp_drain = 1'b0;
        bus.rsp_v     = 1'b0;
        #1;
        checks++;
        if (bus.rsp_vacancy !== 7'd10 || bus.credit_err !== 1'b0) begin
            errors++;
            $display("FAIL same_net: rsp_vac=%0d err=%b required 10 0", bus.rsp_vacancy, bus.credit_err);
        end
        for (int c = 0; c < 4; c++) begin
            bus.word_yumi = m_busy();
            tick();
        end
        bus.word_yumi = 1'b0;
        pulse_reset();
        bus.rsp_drain = 1'b1;
        tick();
        bus.rsp_drain = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (bus.rsp_vacancy !== 7'd64 || bus.credit_err !== 1'b1) begin
            errors++;
            $display("FAIL same_overflow: rsp_vac=%0d err=%b required 64 1", bus.rsp_vacancy, bus.credit_err);
        end
        pulse_reset();
        #1;
        checks++;
        if (bus.credit_err !== 1'b0) begin
            errors++;
            $display("FAIL same_err_clear: err=%b required 0", bus.credit_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d, d2;
        pulse_reset();
        d = {$urandom, $urandom, $urandom, $urandom};
        bus.rsp_v    = 1'b1;
        bus.rsp_data = d;
        tick();
        bus.rsp_v     = 1'b0;
        bus.word_yumi = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (bus.word_data !== d[95:64] || bus.rsp_vacancy !== 7'd63) begin
            errors++;
            $display("FAIL mid_beat2: data=%h rsp_vac=%0d required %h 63", bus.word_data, bus.rsp_vacancy, d[95:64]);
        end
        bus.word_yumi = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        d2 = {$urandom, $urandom, $urandom, $urandom};
        bus.rsp_v    = 1'b1;
        bus.rsp_data = d2;
        bus.req_v    = 1'b1;
        bus.req_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        checks++;
        if ({bus.word_v, bus.rsp_ready, bus.req_ready} !== 3'b010 ||
            bus.rsp_vacancy !== 7'd64 || bus.req_vacancy !== 7'd64) begin
            errors++;
            $display("FAIL mid_after: v/rsp_rdy/req_rdy=%b vac=%0d/%0d required 010 64/64",
                     {bus.word_v, bus.rsp_ready, bus.req_ready}, bus.rsp_vacancy, bus.req_vacancy);
        end
        tick();
        drive_idle();
        bus.word_yumi = 1'b1;
        #1;
        checks++;
        if ({bus.word_v, bus.word_src, bus.word_data} !== {1'b1, 1'b0, d2[31:0]}) begin
            errors++;
            $display("FAIL mid_restart: v=%b src=%b data=%h required 1 0 %h",
                     bus.word_v, bus.word_src, bus.word_data, d2[31:0]);
        end
        for (int c = 0; c < 4; c++) begin
            bus.word_yumi = m_busy();
            tick();
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic [51:0] exp_vec, act_vec;
        int g;
        bit busy;
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.rsp_v     = ($urandom_range(0, 2) != 0);
            bus.req_v     = ($urandom_range(0, 2) != 0);
            bus.rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.word_yumi = m_busy() && ($urandom_range(0, 3) != 0);
            bus.rsp_drain = ($urandom_range(0, 13) == 0);
            bus.req_drain = ($urandom_range(0, 13) == 0);
            reset         = ($urandom_range(0, 599) == 0);
            #1;
            g    = m_grant();
            busy = m_busy();
            exp_vec = {(g == 0), (g == 1), busy, busy ? m_src : 1'b0,
                       busy && (m_words.size() == 1), busy ? m_words[0] : 32'h0,
                       7'(m_vac[0]), 7'(m_vac[1]), m_err};
            act_vec = {bus.rsp_ready, bus.req_ready, bus.word_v, bus.word_src, bus.word_last,
                       bus.word_data, bus.rsp_vacancy, bus.req_vacancy, bus.credit_err};
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL random c=%0d: rdy/v/src/last/data/vac/vac/err=%h required %h", c, act_vec, exp_vec);
            end
            tick();
        end
        reset = 1'b0;
        drive_idle();
    endtask

    initial begin
        model_reset();
        drive_idle();
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_rsp();
        test_alternate();
        test_credit_exhaust();
        test_backpressure();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end
endmodule
